// File: rtl/spi_pkg.sv
// Shared SPI definitions: burst-sequencer FSM states, byte-engine mode constants
// and small elaboration helpers.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_SEND = 3'd2,
        ST_XFER = 3'd3,
        ST_NEXT = 3'd4,
        ST_LAG  = 3'd5,
        ST_GAP  = 3'd6
    } seq_state_e;

    // SPI modes as {CPOL, CPHA}, matching the byte engine's SPI_MODE parameter
    localparam logic [1:0] SPI_MODE_0 = 2'b00;
    localparam logic [1:0] SPI_MODE_1 = 2'b01;
    localparam logic [1:0] SPI_MODE_2 = 2'b10;
    localparam logic [1:0] SPI_MODE_3 = 2'b11;

    function automatic int spi_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_seq_delay_cnt.sv
// Loadable down-counter with a done flag; times the CS lead/lag/gap phases
// and the wait for the next user byte.
module spi_seq_delay_cnt #(
    parameter int W = 4
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Load,
    input  logic [W-1:0] i_Value,
    output logic         o_Done
);

    logic [W-1:0] r_count;

    // Load wins over counting; the count parks at zero.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_count <= {W{1'b0}};
        end else if (i_Load) begin
            r_count <= i_Value;
        end else if (r_count != {W{1'b0}}) begin
            r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_Done = (r_count == {W{1'b0}});

endmodule

// File: rtl/spi_cs_sequencer.sv
// Multi-byte SPI burst controller above the byte engine: owns CS lead/lag/idle
// timing and indexes received bytes. SPI_SEQ_TIMEOUT_EN adds o_Timeout.
module spi_cs_sequencer
    import spi_pkg::*;
#(
    parameter int COUNT_W      = 8,
    parameter int CS_LEAD_CLKS = 2,
    parameter int CS_LAG_CLKS  = 2,
    parameter int CS_IDLE_CLKS = 4,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [COUNT_W-1:0] i_TX_Count,
    input  logic [7:0]         i_TX_Byte,
    input  logic               i_TX_DV,
    output logic               o_TX_Ready,
    output logic               o_RX_DV,
    output logic [7:0]         o_RX_Byte,
    output logic [COUNT_W-1:0] o_RX_Index,
    output logic               o_Busy,
    output logic               o_SPI_CS_n,
`ifdef SPI_SEQ_TIMEOUT_EN
    output logic               o_Timeout,
`endif
    output logic [7:0]         o_Eng_TX_Byte,
    output logic               o_Eng_TX_DV,
    input  logic               i_Eng_TX_Ready,
    input  logic               i_Eng_RX_DV,
    input  logic [7:0]         i_Eng_RX_Byte
);

    localparam int DLY_MAX = spi_max(spi_max(CS_LEAD_CLKS, CS_LAG_CLKS),
                                     spi_max(CS_IDLE_CLKS, TIMEOUT_CLKS));
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    // Loading N-1 makes the phase last exactly N cycles before done is acted on.
    localparam logic [DLY_W-1:0]   LEAD_LD = DLY_W'(CS_LEAD_CLKS - 1);
    localparam logic [DLY_W-1:0]   LAG_LD  = DLY_W'(CS_LAG_CLKS - 1);
    localparam logic [DLY_W-1:0]   GAP_LD  = DLY_W'(CS_IDLE_CLKS - 1);
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam logic [DLY_W-1:0]   TO_LD   = DLY_W'(TIMEOUT_CLKS - 1);
`endif
    localparam logic [COUNT_W-1:0] ONE_C   = COUNT_W'(1);

    seq_state_e         r_state, w_state_nxt;
    logic [7:0]         r_tx_byte, w_tx_byte_nxt;
    logic [COUNT_W-1:0] r_remaining, w_remaining_nxt;
    logic [COUNT_W-1:0] r_rx_index, w_rx_index_nxt;
    logic [7:0]         r_rx_byte, w_rx_byte_nxt;
    logic               r_rx_dv, w_rx_dv_nxt;
    logic               r_cs_n, w_cs_n_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_tx_ready, w_tx_ready_nxt;
    logic               r_eng_dv, w_eng_dv_nxt;
    logic [7:0]         r_eng_byte, w_eng_byte_nxt;
`ifdef SPI_SEQ_TIMEOUT_EN
    logic               r_timeout, w_timeout_nxt;
`endif
    logic               w_issue;
    logic               w_dly_load;
    logic [DLY_W-1:0]   w_dly_value;
    logic               w_dly_done;

    spi_seq_delay_cnt #(.W(DLY_W)) u_dly (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Load  (w_dly_load),
        .i_Value (w_dly_value),
        .o_Done  (w_dly_done)
    );

    // Next-state and next-output logic for every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_tx_byte_nxt   = r_tx_byte;
        w_remaining_nxt = r_remaining;
        w_rx_index_nxt  = r_rx_index;
        w_rx_byte_nxt   = r_rx_byte;
        w_rx_dv_nxt     = 1'b0;
        w_cs_n_nxt      = r_cs_n;
        w_busy_nxt      = r_busy;
        w_tx_ready_nxt  = r_tx_ready;
        w_eng_dv_nxt    = 1'b0;
        w_eng_byte_nxt  = r_eng_byte;
`ifdef SPI_SEQ_TIMEOUT_EN
        w_timeout_nxt   = 1'b0;
`endif
        w_issue         = 1'b0;
        w_dly_load      = 1'b0;
        w_dly_value     = {DLY_W{1'b0}};

        case (r_state)
            ST_IDLE: begin
                if (i_TX_DV && r_tx_ready && (i_TX_Count != {COUNT_W{1'b0}})) begin
                    w_tx_byte_nxt   = i_TX_Byte;
                    w_remaining_nxt = i_TX_Count;
                    w_rx_index_nxt  = {COUNT_W{1'b0}};
                    w_cs_n_nxt      = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_tx_ready_nxt  = 1'b0;
                    w_dly_load      = 1'b1;
                    w_dly_value     = LEAD_LD;
                    w_state_nxt     = ST_LEAD;
                end else begin
                    w_tx_ready_nxt  = 1'b1;
                end
            end
            // The first byte goes out on the edge that ends LEAD when the engine is free.
            ST_LEAD: begin
                if (w_dly_done) begin
                    if (i_Eng_TX_Ready) begin
                        w_issue     = 1'b1;
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end else begin
                    w_state_nxt = ST_LEAD;
                end
            end
            ST_SEND: begin
                if (i_Eng_TX_Ready) begin
                    w_issue     = 1'b1;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_XFER: begin
                if (i_Eng_RX_DV) begin
                    w_rx_dv_nxt    = 1'b1;
                    w_rx_byte_nxt  = i_Eng_RX_Byte;
                    w_rx_index_nxt = r_rx_index + ONE_C;
                    if (r_remaining == {COUNT_W{1'b0}}) begin
                        w_dly_load  = 1'b1;
                        w_dly_value = LAG_LD;
                        w_state_nxt = ST_LAG;
                    end else begin
                        w_tx_ready_nxt = 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
                        w_dly_load     = 1'b1;
                        w_dly_value    = TO_LD;
`endif
                        w_state_nxt    = ST_NEXT;
                    end
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_NEXT: begin
                if (i_TX_DV && r_tx_ready) begin
                    w_tx_byte_nxt  = i_TX_Byte;
                    w_tx_ready_nxt = 1'b0;
                    w_state_nxt    = ST_SEND;
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (w_dly_done) begin
                    w_timeout_nxt   = 1'b1;
                    w_tx_ready_nxt  = 1'b0;
                    w_remaining_nxt = {COUNT_W{1'b0}};
                    w_dly_load      = 1'b1;
                    w_dly_value     = LAG_LD;
                    w_state_nxt     = ST_LAG;
                end
`endif
                else begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_LAG: begin
                if (w_dly_done) begin
                    w_cs_n_nxt  = 1'b1;
                    w_dly_load  = 1'b1;
                    w_dly_value = GAP_LD;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_LAG;
                end
            end
            ST_GAP: begin
                if (w_dly_done) begin
                    w_busy_nxt     = 1'b0;
                    w_tx_ready_nxt = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_state_nxt    = ST_GAP;
                end
            end
            default: begin
                w_cs_n_nxt     = 1'b1;
                w_busy_nxt     = 1'b0;
                w_tx_ready_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase

        if (w_issue) begin
            w_eng_dv_nxt    = 1'b1;
            w_eng_byte_nxt  = r_tx_byte;
            w_remaining_nxt = r_remaining - ONE_C;
            w_state_nxt     = ST_XFER;
        end else begin
            w_eng_dv_nxt    = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state     <= ST_IDLE;
            r_tx_byte   <= 8'h00;
            r_remaining <= {COUNT_W{1'b0}};
            r_rx_index  <= {COUNT_W{1'b0}};
            r_rx_byte   <= 8'h00;
            r_rx_dv     <= 1'b0;
            r_cs_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_eng_dv    <= 1'b0;
            r_eng_byte  <= 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_remaining <= w_remaining_nxt;
            r_rx_index  <= w_rx_index_nxt;
            r_rx_byte   <= w_rx_byte_nxt;
            r_rx_dv     <= w_rx_dv_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_busy      <= w_busy_nxt;
            r_tx_ready  <= w_tx_ready_nxt;
            r_eng_dv    <= w_eng_dv_nxt;
            r_eng_byte  <= w_eng_byte_nxt;
`ifdef SPI_SEQ_TIMEOUT_EN
            r_timeout   <= w_timeout_nxt;
`endif
        end
    end

    assign o_TX_Ready    = r_tx_ready;
    assign o_RX_DV       = r_rx_dv;
    assign o_RX_Byte     = r_rx_byte;
    assign o_RX_Index    = r_rx_index;
    assign o_Busy        = r_busy;
    assign o_SPI_CS_n    = r_cs_n;
    assign o_Eng_TX_Byte = r_eng_byte;
    assign o_Eng_TX_DV   = r_eng_dv;
`ifdef SPI_SEQ_TIMEOUT_EN
    assign o_Timeout     = r_timeout;
`endif

endmodule

// File: doc/spi_cs_sequencer.md
Name: spi_cs_sequencer

Overview:
- Transaction controller that sits above the SPI byte engine (the existing SPI master) and sequences multi-byte bursts under a single chip-select.
- Owns CS timing (lead, lag, minimum deassert), feeds bytes to the engine one at a time, and forwards received bytes to the user with a running index.
- Instantiated beside the byte engine in the SPI top level. The engine's active-low reset is driven by ~i_Rst.

Parameters:
- COUNT_W, 8, width of the byte-count and index fields; maximum burst is 2^COUNT_W-1 bytes.
- CS_LEAD_CLKS, 2, cycles from CS_n falling to the first engine DV; must be >=1.
- CS_LAG_CLKS, 2, cycles from last byte done to CS_n rising; must be >=1.
- CS_IDLE_CLKS, 4, minimum cycles CS_n stays high before the next burst; must be >=1.
- TIMEOUT_CLKS, 1024, wait limit for the next user byte; used only with SPI_SEQ_TIMEOUT_EN.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset, synchronous, active-high.
- i_TX_Count  in  COUNT_W  bytes in the burst; sampled only on the accepted first byte.
- i_TX_Byte  in  8  byte to send.
- i_TX_DV  in  1  byte valid; accepted only when o_TX_Ready=1.
- o_TX_Ready  out  1  controller can accept a byte.
- o_RX_DV  out  1  one-cycle pulse: received byte valid.
- o_RX_Byte  out  8  received byte.
- o_RX_Index  out  COUNT_W  1-based position of o_RX_Byte in the burst.
- o_Busy  out  1  high from CS assert until the end of the CS_IDLE phase.
- o_SPI_CS_n  out  1  chip select, active-low.
- o_Eng_TX_Byte  out  8  to engine i_TX_Byte.
- o_Eng_TX_DV  out  1  to engine i_TX_DV, one-cycle pulse.
- i_Eng_TX_Ready  in  1  from engine o_TX_Ready.
- i_Eng_RX_DV  in  1  from engine o_RX_DV.
- i_Eng_RX_Byte  in  8  from engine o_RX_Byte.

Behaviour:
- Reset values: o_SPI_CS_n=1, o_TX_Ready=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Index=0, o_Busy=0, o_Eng_TX_DV=0, o_Eng_TX_Byte=0. FSM resets to IDLE. o_TX_Ready rises 1 cycle after i_Rst deasserts. All outputs are registered.
- IDLE: o_TX_Ready=1.
  - i_TX_DV with i_TX_Count!=0: latch the byte and the count into remaining; o_RX_Index<=0; o_SPI_CS_n<=0; o_Busy<=1; o_TX_Ready<=0; go to LEAD.
  - i_TX_DV with i_TX_Count==0: byte dropped, no CS activity, stay in IDLE.
- LEAD: lasts exactly CS_LEAD_CLKS cycles, then go to SEND.
- SEND: wait until i_Eng_TX_Ready=1, then pulse o_Eng_TX_DV for 1 cycle with the latched byte. remaining-=1. Go to XFER.
- XFER: on i_Eng_RX_DV, next cycle o_RX_DV=1, o_RX_Byte=i_Eng_RX_Byte, o_RX_Index+=1.
  - remaining==0: go to LAG.
  - remaining!=0: go to NEXT with o_TX_Ready<=1.
- NEXT: CS_n stays low indefinitely while waiting. On i_TX_DV, latch the byte, o_TX_Ready<=0, go to SEND. i_TX_Count is ignored here.
- LAG: lasts exactly CS_LAG_CLKS cycles, then o_SPI_CS_n<=1 and go to GAP.
- GAP: lasts exactly CS_IDLE_CLKS cycles, then o_Busy<=0, o_TX_Ready<=1, go to IDLE.
- i_TX_DV while o_TX_Ready=0 is ignored: no latch, no side effects.
- A spurious i_Eng_RX_DV outside XFER is ignored.
- o_RX_Index does not wrap: the counter width equals the maximum count.
- Reset mid-burst: next edge forces o_SPI_CS_n=1, o_Eng_TX_DV=0, o_RX_DV=0, FSM to IDLE. The engine is reset by the same signal, so no partial byte is reported.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- With the macro: adds output o_Timeout (1-bit, reset 0) and a counter active in NEXT. If no i_TX_DV arrives for TIMEOUT_CLKS consecutive cycles:
  - pulse o_Timeout for 1 cycle;
  - o_TX_Ready<=0;
  - go to LAG, so CS is released with normal lag and gap.
  - remaining is discarded.
- Without the macro: no port, no counter, and NEXT waits forever.

Decomposition:
- Shared package spi_pkg: FSM state enum (IDLE, LEAD, SEND, XFER, NEXT, LAG, GAP) and the SPI mode constants already used by the byte engine.
- One sub-module, spi_seq_delay_cnt: a loadable down-counter with a done flag, reused for the LEAD/LAG/GAP durations and for the timeout.

Test Plan:
- Single byte: count=1, byte 0xA5, engine MISO looped to MOSI -> one o_RX_DV with o_RX_Byte=0xA5, o_RX_Index=1; CS_n low for exactly CS_LEAD_CLKS + transfer + CS_LAG_CLKS cycles.
- Burst of 3: bytes 0x01, 0x02, 0x03, with the user stalling 10 cycles before byte 2 -> CS_n stays low throughout; three RX pulses with index 1, 2, 3; exactly three o_Eng_TX_DV pulses.
- Zero count: i_TX_DV with i_TX_Count=0 -> CS_n stays 1, o_TX_Ready stays 1, no engine DV.
- Back-to-back bursts: second i_TX_DV held high continuously -> not accepted until GAP completes; CS_n high for >= CS_IDLE_CLKS cycles.
- Reset at the 4th SPI edge of byte 2 of a 3-byte burst -> CS_n=1 on the next cycle, no o_RX_DV; a new 1-byte burst then completes normally.
- Macro on, TIMEOUT_CLKS=16: count=2, second byte never sent -> o_Timeout pulses 16 cycles after o_TX_Ready rises in NEXT, CS_n rises after the lag.
